pong_vga_timing_driver: RTL and testbench



---
 rtl/pong_vga_timing_driver.sv | 122 ++++++++++++
 tb/tb_pong_vga_timing_driver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_vga_timing_driver.sv
// Raster timing master for the pong pixel interface. It generates the counters and
// strobes, and registers the engine colour onto VGA pins with sync delayed to match.
module pong_vga_timing_driver #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int H_CNT_WID       = 10,
  parameter int V_CNT_WID       = 10,
  parameter int PIPELINE_STAGES = 1,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                 pixIf_CLK,
  input  logic                 rst,
  output logic [H_CNT_WID-1:0] pixIf_H_CNT,
  output logic [V_CNT_WID-1:0] pixIf_next_V_CNT,
  output logic                 pixIf_H_BLANKING,
  output logic                 pixIf_NEXT_FRAME,
  input  logic [3:0]           pixIf_r,
  input  logic [3:0]           pixIf_g,
  input  logic [3:0]           pixIf_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_WID-1:0] H_LAST       = H_CNT_WID'(H_TOTAL - 1);
  localparam logic [H_CNT_WID-1:0] H_VIS_END    = H_CNT_WID'(H_VISIBLE);
  localparam logic [H_CNT_WID-1:0] H_SYNC_START = H_CNT_WID'(H_VISIBLE + H_FP);
  localparam logic [H_CNT_WID-1:0] H_SYNC_END   = H_CNT_WID'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [H_CNT_WID-1:0] H_ONE        = H_CNT_WID'(1);

  localparam logic [V_CNT_WID-1:0] V_LAST       = V_CNT_WID'(V_TOTAL - 1);
  localparam logic [V_CNT_WID-1:0] V_VIS_END    = V_CNT_WID'(V_VISIBLE);
  localparam logic [V_CNT_WID-1:0] V_VIS_LAST   = V_CNT_WID'(V_VISIBLE - 1);
  localparam logic [V_CNT_WID-1:0] V_SYNC_START = V_CNT_WID'(V_VISIBLE + V_FP);
  localparam logic [V_CNT_WID-1:0] V_SYNC_END   = V_CNT_WID'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [V_CNT_WID-1:0] V_ONE        = V_CNT_WID'(1);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } flags_t;

  logic [H_CNT_WID-1:0] h_cnt;
  logic [V_CNT_WID-1:0] v_cnt;
  flags_t               raw;
  flags_t               dly;

  always_ff @(posedge pixIf_CLK) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_ONE;
    end else begin
      h_cnt <= h_cnt + H_ONE;
    end
  end

  assign pixIf_H_CNT      = h_cnt;
  assign pixIf_H_BLANKING = (h_cnt >= H_VIS_END);
  assign pixIf_next_V_CNT = (v_cnt == V_LAST) ? '0 : v_cnt + V_ONE;
  assign pixIf_NEXT_FRAME = (h_cnt == H_VIS_END) && (v_cnt == V_VIS_LAST);

  always_comb begin
    // NOTE: every field is written on every pass, so no latch can be inferred.
    raw.de = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    raw.hs = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    raw.vs = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
  end

  // Delay the flags by the engine latency so they meet the matching colour.
  generate
    if (PIPELINE_STAGES == 0) begin : g_no_delay
      assign dly = raw;
    end else begin : g_delay
      flags_t sr [PIPELINE_STAGES];

      always_ff @(posedge pixIf_CLK) begin
        if (rst) begin
          // NOTE: this shift register is reset on purpose; stale flags would glitch the pins on release.
          for (int i = 0; i < PIPELINE_STAGES; i++) sr[i] <= '0;
        end else begin
          sr[0] <= raw;
          for (int i = 1; i < PIPELINE_STAGES; i++) sr[i] <= sr[i-1];
        end
      end

      assign dly = sr[PIPELINE_STAGES-1];
    end
  endgenerate

  always_ff @(posedge pixIf_CLK) begin
    if (rst) begin
      vga_hsync <= SYNC_ACTIVE_LOW;
      vga_vsync <= SYNC_ACTIVE_LOW;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else begin
      vga_hsync <= dly.hs ^ SYNC_ACTIVE_LOW;
      vga_vsync <= dly.vs ^ SYNC_ACTIVE_LOW;
      vga_r     <= dly.de ? pixIf_r : '0;
      vga_g     <= dly.de ? pixIf_g : '0;
      vga_b     <= dly.de ? pixIf_b : '0;
    end
  end

endmodule

// File: tb/tb_pong_vga_timing_driver.sv
// Bench for pong_vga_timing_driver: one default-timing instance plus three small-raster
// instances (various latency/polarity), each with an engine model and a pin scoreboard.
module tb_pong_vga_timing_driver;

  localparam int NI = 4;
  localparam int HV [NI] = '{640, 8, 8, 8};
  localparam int HF [NI] = '{16, 2, 2, 2};
  localparam int HS [NI] = '{96, 3, 3, 3};
  localparam int HB [NI] = '{48, 3, 3, 3};
  localparam int VV [NI] = '{480, 6, 6, 6};
  localparam int VF [NI] = '{10, 2, 2, 2};
  localparam int VS [NI] = '{2, 2, 2, 2};
  localparam int VB [NI] = '{33, 2, 2, 2};
  localparam int PS [NI] = '{1, 0, 1, 3};
  localparam bit SAL [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pins_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_o     [NI];
  logic [9:0] nv_o    [NI];
  logic       blank_o [NI];
  logic       nf_o    [NI];
  logic       hsync_o [NI];
  logic       vsync_o [NI];
  logic [3:0] vr_o    [NI];
  logic [3:0] vg_o    [NI];
  logic [3:0] vb_o    [NI];

  logic [11:0] eng_in   [NI];
  logic [11:0] eng_out  [NI];
  logic [11:0] eng_pipe [NI][3];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    hm [NI];
  int    vm [NI];
  bit    armed [NI];
  bit    rst_edge = 1'b0;
  pins_t sb_q [NI][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pong_vga_timing_driver #(
      .H_VISIBLE(HV[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
      .V_VISIBLE(VV[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
      .H_CNT_WID(10), .V_CNT_WID(10),
      .PIPELINE_STAGES(PS[g]), .SYNC_ACTIVE_LOW(SAL[g])
    ) u_dut (
      .pixIf_CLK       (clk),
      .rst             (rst),
      .pixIf_H_CNT     (h_o[g]),
      .pixIf_next_V_CNT(nv_o[g]),
      .pixIf_H_BLANKING(blank_o[g]),
      .pixIf_NEXT_FRAME(nf_o[g]),
      .pixIf_r         (eng_out[g][11:8]),
      .pixIf_g         (eng_out[g][7:4]),
      .pixIf_b         (eng_out[g][3:0]),
      .vga_hsync       (hsync_o[g]),
      .vga_vsync       (vsync_o[g]),
      .vga_r           (vr_o[g]),
      .vga_g           (vg_o[g]),
      .vga_b           (vb_o[g])
    );
  end

  // Engine model: r is 0xF whenever blanking (must be ignored), else h mod 16.
  always_comb begin
    for (int i = 0; i < NI; i++)
      eng_in[i] = {blank_o[i] ? 4'hF : h_o[i][3:0], ~h_o[i][3:0], h_o[i][7:4]};
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      eng_pipe[i][0] <= eng_in[i];
      eng_pipe[i][1] <= eng_pipe[i][0];
      eng_pipe[i][2] <= eng_pipe[i][1];
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      case (PS[i])
        0:       eng_out[i] = eng_in[i];
        1:       eng_out[i] = eng_pipe[i][0];
        2:       eng_out[i] = eng_pipe[i][1];
        default: eng_out[i] = eng_pipe[i][2];
      endcase
    end
  end

  function automatic int h_total(input int i);
    return HV[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int v_total(input int i);
    return VV[i] + VF[i] + VS[i] + VB[i];
  endfunction

  // Independent raster model.
  always @(posedge clk) begin
    rst_edge <= rst;
    for (int i = 0; i < NI; i++) begin
      armed[i] <= armed[i] | rst;
      if (rst) begin
        hm[i] <= 0;
        vm[i] <= 0;
      end else if (hm[i] == h_total(i) - 1) begin
        hm[i] <= 0;
        vm[i] <= (vm[i] == v_total(i) - 1) ? 0 : vm[i] + 1;
      end else begin
        hm[i] <= hm[i] + 1;
      end
    end
  end

  function automatic pins_t idle_pins(input int i);
    pins_t p;
    p.hs  = SAL[i];
    p.vs  = SAL[i];
    p.rgb = 12'h000;
    return p;
  endfunction

  function automatic pins_t exp_pins(input int i);
    pins_t      p;
    logic [9:0] hh;
    bit         de, hs, vs;
    hh    = hm[i][9:0];
    de    = (hm[i] < HV[i]) && (vm[i] < VV[i]);
    hs    = (hm[i] >= HV[i] + HF[i]) && (hm[i] < HV[i] + HF[i] + HS[i]);
    vs    = (vm[i] >= VV[i] + VF[i]) && (vm[i] < VV[i] + VF[i] + VS[i]);
    p.hs  = hs ^ SAL[i];
    p.vs  = vs ^ SAL[i];
    p.rgb = de ? {hh[3:0], ~hh[3:0], hh[7:4]} : 12'h000;
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: push the expected pins for the current raster state, pop them
  // PIPELINE_STAGES+1 clocks later. A reset edge refills the pipe with idle pins.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_edge) begin
        sb_q[i].delete();
        for (int k = 0; k <= PS[i]; k++) sb_q[i].push_back(idle_pins(i));
      end
      if (armed[i]) begin
        check($sformatf("d%0d_h_cnt", i), h_o[i], hm[i]);
        check($sformatf("d%0d_blank", i), blank_o[i], hm[i] >= HV[i]);
        check($sformatf("d%0d_next_v", i), nv_o[i],
              (vm[i] == v_total(i) - 1) ? 0 : vm[i] + 1);
        check($sformatf("d%0d_next_frame", i), nf_o[i],
              (hm[i] == HV[i]) && (vm[i] == VV[i] - 1));
        sb_q[i].push_back(exp_pins(i));
        if (sb_q[i].size() > PS[i] + 1) begin
          pins_t e;
          e = sb_q[i].pop_front();
          check($sformatf("d%0d_pins", i),
                {hsync_o[i], vsync_o[i], vr_o[i], vg_o[i], vb_o[i]}, e);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int cnt_a, cnt_b, cnt_c, cnt_d;
    int order [NI] = '{1, 2, 3, 0};

    // Reset state.
    step(3);
    rst = 1'b0;
    check("rst_h_cnt", h_o[0], 0);
    check("rst_next_v", nv_o[0], 1);
    check("rst_blank", blank_o[0], 0);
    check("rst_next_frame", nf_o[0], 0);
    check("rst_pins_d0", {hsync_o[0], vsync_o[0], vr_o[0], vg_o[0], vb_o[0]}, 14'h3000);
    check("rst_pins_d1", {hsync_o[1], vsync_o[1], vr_o[1], vg_o[1], vb_o[1]}, 14'h0000);

    // Pin latency: first visible pixel (g = ~0 = 0xF at h = 0) reaches the pins after P+1 clocks.
    foreach (order[j]) begin
      pulse_reset();
      k = 0;
      while (vg_o[order[j]] == 4'h0 && k < 20) begin
        step(1);
        k++;
      end
      check($sformatf("latency_d%0d", order[j]), k, PS[order[j]] + 1);
    end

    // hsync window on the default raster.
    k = 0;
    while (h_o[0] != 10'd656 && k < 1000) begin
      step(1);
      k++;
    end
    check("wait_h656", h_o[0], 656);
    k = 0;
    while (hsync_o[0] !== 1'b0 && k < 10) begin
      step(1);
      k++;
    end
    check("hs_first_low", k, 2);
    cnt_a = 1;
    repeat (799) begin
      step(1);
      if (hsync_o[0] == 1'b0) cnt_a++;
    end
    check("hs_low_len", cnt_a, 96);

    // Blanking colour is dropped even though the engine drives 0xF.
    k = 0;
    while (h_o[0] != 10'd700 && k < 1000) begin
      step(1);
      k++;
    end
    step(2);
    check("blank_rgb", {vr_o[0], vg_o[0], vb_o[0]}, 12'h000);
    k = 0;
    while (h_o[0] != 10'd10 && k < 1000) begin
      step(1);
      k++;
    end
    step(2);
    check("visible_rgb_h10", {vr_o[0], vg_o[0], vb_o[0]}, 12'hA50);

    // Mid-frame reset at h = 300 on line 3.
    k = 0;
    while (!(h_o[0] == 10'd300 && nv_o[0] == 10'd4) && k < 4000) begin
      step(1);
      k++;
    end
    check("wait_h300_v3", {nv_o[0], h_o[0]}, {10'd4, 10'd300});
    pulse_reset();
    check("mid_rst_h_cnt", h_o[0], 0);
    check("mid_rst_next_v", nv_o[0], 1);
    check("mid_rst_pins_d0", {hsync_o[0], vsync_o[0], vr_o[0], vg_o[0], vb_o[0]}, 14'h3000);
    check("mid_rst_pins_d3", {hsync_o[3], vsync_o[3], vr_o[3], vg_o[3], vb_o[3]}, 14'h3000);
    step(1700);

    // One full small frame: strobe count, vsync width, inverted polarity.
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    repeat (16 * 12) begin
      step(1);
      if (nf_o[2] == 1'b1)      cnt_a++;
      if (vsync_o[2] == 1'b0)   cnt_b++;
      if (vsync_o[1] == 1'b1)   cnt_c++;
      if (hsync_o[1] == 1'b1)   cnt_d++;
    end
    check("frame_strobes", cnt_a, 1);
    check("vsync_low_len", cnt_b, 32);
    check("vsync_pos_len", cnt_c, 32);
    check("hsync_pos_len", cnt_d, 36);
    step(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
